// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: one-hot op encoding, op bit
// indices and the default operand width.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam int OP_ADD_BIT = 0;
    localparam int OP_SUB_BIT = 1;
    localparam int OP_XOR_BIT = 2;
    localparam int OP_OR_BIT  = 3;
    localparam int OP_AND_BIT = 4;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00001 << OP_ADD_BIT,
        ALU_SUB = 5'b00001 << OP_SUB_BIT,
        ALU_XOR = 5'b00001 << OP_XOR_BIT,
        ALU_OR  = 5'b00001 << OP_OR_BIT,
        ALU_AND = 5'b00001 << OP_AND_BIT
    } alu_op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Any op that is not exactly
// one-hot produces a zero result with the error flag set.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_err
);

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (alu_op_t'(i_op))
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_AND: o_result = i_a & i_b;
            default: o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a one-entry
// result register. Optional perf counters enabled by ALU_ARBITER_PERF_EN.
//
// state    | meaning
// ST_EMPTY | result register holds nothing, rsp_valid = 0
// ST_FULL  | result register holds a result, rsp_valid = 1
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_op,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [TAG_W-1:0] req0_tag,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_op,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [TAG_W-1:0] req1_tag,

`ifdef ALU_ARBITER_PERF_EN
    output logic [31:0]      grant_cnt0,
    output logic [31:0]      grant_cnt1,
    output logic [31:0]      stall_cnt,
`endif

    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_err
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             r_state;
    logic             r_last;
    logic             r_id;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_data;
    logic             r_err;

    logic             w_can_accept;
    logic             w_pick0;
    logic             w_pick1;
    logic             w_accept;
    logic [4:0]       w_op;
    logic [XLEN-1:0]  w_a;
    logic [XLEN-1:0]  w_b;
    logic [TAG_W-1:0] w_tag;
    logic [XLEN-1:0]  w_result;
    logic             w_err;

    // rst_n gates acceptance so no handshake completes while reset is held.
    assign w_can_accept = rst_n & ((r_state == ST_EMPTY) | rsp_ready);

    // r_last = 1 means requester 1 was granted most recently.
    assign w_pick0 = req0_valid & (~req1_valid | r_last);
    assign w_pick1 = req1_valid & (~req0_valid | ~r_last);

    assign req0_ready = w_can_accept & w_pick0;
    assign req1_ready = w_can_accept & w_pick1;
    assign w_accept   = req0_ready | req1_ready;

    always_comb begin
        w_op  = req0_op;
        w_a   = req0_a;
        w_b   = req0_b;
        w_tag = req0_tag;
        if (w_pick1) begin
            w_op  = req1_op;
            w_a   = req1_a;
            w_b   = req1_b;
            w_tag = req1_tag;
        end
    end

    alu_arbiter_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_op     (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_result),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= ST_FULL;
                r_last  <= req1_ready;
                r_id    <= req1_ready;
                r_tag   <= w_tag;
                r_data  <= w_result;
                r_err   <= w_err;
            end else if (rsp_ready) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_id    = r_id;
    assign rsp_tag   = r_tag;
    assign rsp_data  = r_data;
    assign rsp_err   = r_err;

`ifdef ALU_ARBITER_PERF_EN
    logic w_stall;

    assign w_stall = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (req0_ready) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (req1_ready) grant_cnt1 <= grant_cnt1 + 32'd1;
            if (w_stall)    stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (default 32-bit build).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp_ready, rsp_valid, rsp_id, rsp_err;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_data;
`ifdef ALU_ARBITER_PERF_EN
    logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
    logic [31:0] stall_base;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_tag   (req1_tag),
`ifdef ALU_ARBITER_PERF_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .stall_cnt  (stall_cnt),
`endif
        .rsp_ready  (rsp_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_tag    (rsp_tag),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    endtask

    task automatic drive1(input logic v, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic id,
                           input logic [3:0] t, input logic [31:0] d, input logic e);
        chk({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, v});
        chk({tag, ".id"},    {31'd0, rsp_id},    {31'd0, id});
        chk({tag, ".tag"},   {28'd0, rsp_tag},   {28'd0, t});
        chk({tag, ".data"},  rsp_data, d);
        chk({tag, ".err"},   {31'd0, rsp_err},   {31'd0, e});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, r0});
        chk({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive0(1'b1, 5'b00001, 32'd1, 32'd1, 4'd1);
        drive1(1'b1, 5'b00001, 32'd2, 32'd2, 4'd2);
        #2;
        chk_rsp("reset", 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        chk_rdy("reset", 1'b0, 1'b0);
        tick();
        tick();
        drive0(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        rst_n = 1'b1;
        tick();
        chk("idle.valid", {31'd0, rsp_valid}, 32'd0);

        // single requester: 5 + 7
        drive0(1'b1, 5'b00001, 32'd5, 32'd7, 4'd3);
        #1;
        chk_rdy("single", 1'b1, 1'b0);
        tick();
        drive0(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        chk_rsp("single", 1'b1, 1'b0, 4'd3, 32'd12, 1'b0);
        tick();
        chk("drain.valid", {31'd0, rsp_valid}, 32'd0);

        // lone req1 OR, leaves pointer at "last granted 1"
        drive1(1'b1, 5'b01000, 32'h0000_00F0, 32'h0000_000C, 4'd9);
        #1;
        chk_rdy("lone1", 1'b0, 1'b1);
        tick();
        drive1(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        chk_rsp("lone1", 1'b1, 1'b1, 4'd9, 32'h0000_00FC, 1'b0);
        tick();

        // contention: grants alternate 0,1,0,1
        drive0(1'b1, 5'b00010, 32'd10, 32'd3, 4'd1);
        drive1(1'b1, 5'b00100, 32'h0000_00F0, 32'h0000_00FF, 4'd2);
        #1;
        chk_rdy("cont0", 1'b1, 1'b0);
        tick();
        chk_rsp("cont0", 1'b1, 1'b0, 4'd1, 32'd7, 1'b0);
        chk_rdy("cont1", 1'b0, 1'b1);
        tick();
        chk_rsp("cont1", 1'b1, 1'b1, 4'd2, 32'h0000_000F, 1'b0);
        chk_rdy("cont2", 1'b1, 1'b0);
        tick();
        chk_rsp("cont2", 1'b1, 1'b0, 4'd1, 32'd7, 1'b0);
        chk_rdy("cont3", 1'b0, 1'b1);
        tick();
        chk_rsp("cont3", 1'b1, 1'b1, 4'd2, 32'h0000_000F, 1'b0);

        // backpressure: result held for 3 cycles, nobody accepted
        rsp_ready = 1'b0;
`ifdef ALU_ARBITER_PERF_EN
        stall_base = stall_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy("bp", 1'b0, 1'b0);
            tick();
            chk_rsp("bp", 1'b1, 1'b1, 4'd2, 32'h0000_000F, 1'b0);
        end
`ifdef ALU_ARBITER_PERF_EN
        chk("bp.stall_cnt", stall_cnt - stall_base, 32'd3);
`endif
        rsp_ready = 1'b1;
        #1;
        chk_rdy("bp.release", 1'b1, 1'b0);
        tick();
        chk_rsp("bp.release", 1'b1, 1'b0, 4'd1, 32'd7, 1'b0);
        drive0(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        drive1(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        tick();
        chk("bp.empty", {31'd0, rsp_valid}, 32'd0);

        // wrap-around and illegal ops, back to back on req0
        drive0(1'b1, 5'b00001, 32'hFFFF_FFFF, 32'd1, 4'd5);
        tick();
        chk_rsp("addwrap", 1'b1, 1'b0, 4'd5, 32'd0, 1'b0);
        drive0(1'b1, 5'b00011, 32'd3, 32'd4, 4'd6);
        tick();
        chk_rsp("illegal2", 1'b1, 1'b0, 4'd6, 32'd0, 1'b1);
        drive0(1'b1, 5'b00010, 32'd0, 32'd1, 4'd7);
        tick();
        chk_rsp("subwrap", 1'b1, 1'b0, 4'd7, 32'hFFFF_FFFF, 1'b0);
        drive0(1'b1, 5'b00000, 32'd9, 32'd9, 4'd8);
        tick();
        chk_rsp("illegal0", 1'b1, 1'b0, 4'd8, 32'd0, 1'b1);
        drive0(1'b1, 5'b10000, 32'h0000_F0F0, 32'h0000_FF00, 4'd4);
        tick();
        chk_rsp("and", 1'b1, 1'b0, 4'd4, 32'h0000_F000, 1'b0);

        // reset while FULL with req0 last granted
        drive0(1'b1, 5'b00001, 32'd1, 32'd1, 4'd11);
        tick();
        drive0(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        rsp_ready = 1'b0;
        chk("midop.full", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_rsp("midop.reset", 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        chk("midop.noresp", {31'd0, rsp_valid}, 32'd0);
        drive0(1'b1, 5'b00001, 32'd20, 32'd22, 4'd12);
        drive1(1'b1, 5'b00001, 32'd30, 32'd33, 4'd13);
        #1;
        chk_rdy("post.tie", 1'b1, 1'b0);
        tick();
        chk_rsp("post.tie", 1'b1, 1'b0, 4'd12, 32'd42, 1'b0);
        drive0(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        #1;
        chk_rdy("post.next", 1'b0, 1'b1);
        tick();
        chk_rsp("post.next", 1'b1, 1'b1, 4'd13, 32'd63, 1'b0);
        drive1(1'b0, 5'b00001, 32'd0, 32'd0, 4'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter TAG_W, default 4, requester transaction tag width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports reqN_valid  input  1  request N offered (N = 0, 1).
REQ-006 SHALL have ports reqN_ready  output  1  request N accepted this cycle.
REQ-007 SHALL have ports reqN_op  input  5  one-hot op {and, or, xor, sub, add}, bit 0 = add.
REQ-008 SHALL have ports reqN_a, reqN_b  input  XLEN  operands.
REQ-009 SHALL have ports reqN_tag  input  TAG_W  opaque tag, returned unchanged.
REQ-010 SHALL have port rsp_valid  output  1  result register holds a result.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-012 SHALL have ports rsp_id (output, 1, granted requester index), rsp_tag (output, TAG_W), rsp_data (output, XLEN), rsp_err (output, 1, op not one-hot).

Function
REQ-013 SHALL share one ALU datapath between two requesters: add a+b, sub a-b, xor, or, and, all modulo 2^XLEN.
REQ-014 SHALL treat op zero or more than one bit set as illegal: rsp_data = 0, rsp_err = 1.
REQ-015 SHALL hold a one-entry result register with states EMPTY and FULL.
REQ-016 SHALL define can_accept = !rsp_valid | rsp_ready, allowing accept and drain in the same cycle.
REQ-017 SHALL arbitrate round-robin: one valid requester wins; if both are valid, the one not granted last wins.
REQ-018 SHALL assert reqN_ready only for the winner and only when can_accept; never both in one cycle.
REQ-019 SHALL update the last-grant pointer only on an accepted transfer (valid & ready).
REQ-020 SHALL have latency 1: a request accepted at edge k gives rsp_valid = 1 with its result, id and tag after edge k.
REQ-021 SHALL hold rsp_* stable while rsp_valid & !rsp_ready.
REQ-022 SHALL, when FULL and drained with no new accept, go EMPTY and clear rsp_valid next cycle.
REQ-023 SHALL sustain one result per cycle while rsp_ready = 1 and requests are pending.
REQ-024 SHALL require requesters to hold valid and payload stable until ready; behaviour otherwise is undefined.
REQ-025 SHALL derive reqN_ready combinationally from reqN_valid, rsp_valid, rsp_ready and the pointer, with no path from payload.

Reset
REQ-026 SHALL, while rst_n = 0, force rsp_valid = 0, rsp_data = 0, rsp_tag = 0, rsp_id = 0, rsp_err = 0 and pointer = "last granted 1" (req0 wins first tie).
REQ-027 SHALL hold reqN_ready = 0 during reset.
REQ-028 SHALL discard an in-flight result on reset mid-operation; no response is emitted for it.

Configuration
REQ-029 SHALL, with macro ALU_ARBITER_PERF_EN defined, add outputs grant_cnt0, grant_cnt1 (32-bit, accepted transfers per requester) and stall_cnt (32-bit, cycles with any reqN_valid & !reqN_ready).
REQ-030 SHALL, with ALU_ARBITER_PERF_EN defined, reset all counters to 0 and wrap them at 2^32.
REQ-031 SHALL, without ALU_ARBITER_PERF_EN, omit the counter ports and logic with no other behavioural change.

Structure
REQ-032 SHALL place the one-hot op typedef (alu_op_t), op bit-index constants and the XLEN default in shared package alu_pkg.
REQ-033 SHALL instantiate the existing combinational ALU as its sole sub-module; arbitration, result register and counters live in alu_arbiter.

Verification
REQ-034 Single requester: req0 add a=5 b=7 tag=3, rsp_ready=1 -> next cycle rsp_valid=1, data=12, id=0, tag=3, err=0.
REQ-035 Contention: both valid every cycle, req0 sub 10-3, req1 xor 0xF0^0xFF -> grants 0,1,0,1 in order; results 7 and 0x0F alternate.
REQ-036 Backpressure: rsp_ready=0 for 3 cycles after a result -> rsp_* stable, both reqN_ready=0, stall_cnt +3 when PERF_EN is defined; rsp_ready=1 -> drain and accept in the same cycle.
REQ-037 Wrap and illegal op: add 0xFFFFFFFF+1 -> data=0, err=0; op=5'b00011 -> data=0, err=1.
REQ-038 Reset mid-operation: rst_n low while FULL -> rsp_valid=0 immediately; after release a tie grants req0.
